sn_to_bn: RTL and testbench

//  Stochastic-to-binary converter: counts the ones in a 2**BW-bit stochastic stream and returns the binary value.
//  It is the decode end of the stochastic link. It sits after the stochastic compute lanes and feeds the binary NN datapath.

---
 rtl/s2b_pkg.sv | 28 ++
 rtl/s2b_win_cnt.sv | 34 +++
 rtl/sn_to_bn.sv | 113 +++++++++++
 tb/tb_sn_to_bn.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/s2b_pkg.sv
// Shared types and the decode rule for the stochastic-to-binary converter.
// The decode rule lives here so the bench model applies the same clip/offset
// arithmetic as the datapath.
package s2b_pkg;

  typedef enum logic [1:0] {S2B_IDLE, S2B_ACC, S2B_DONE} s2b_state_t;

  localparam int S2B_BW_DEF = 4;
  localparam int S2B_CLIP_W = 16;

  // Map a ones-count (0..2**bw) to a bw-bit result.
  // Unipolar: min(cnt, L-1). Bipolar: (cnt - L/2) in two's complement,
  // clipped to [-L/2, L/2-1]. Only the low bw bits are meaningful.
  function automatic logic [S2B_CLIP_W-1:0] s2b_clip(input int cnt,
                                                     input logic bipolar,
                                                     input int bw = S2B_BW_DEF);
    int l;
    int r;
    l = 1 << bw;
    if (bipolar) begin
      r = (cnt >= l) ? (l / 2 - 1) : (cnt - l / 2);
    end else begin
      r = (cnt >= l) ? (l - 1) : cnt;
    end
    return S2B_CLIP_W'(r & (l - 1));
  endfunction

endpackage

// File: rtl/s2b_win_cnt.sv
// Window accumulator: counts ones and bit positions inside one window.
// clear has priority over en; last flags the final bit position (idx==L-1).
// cnt_sum is the count including the bit currently presented, so the top can
// capture the complete window total on the last edge.
module s2b_win_cnt #(
  parameter int BW = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        en,
  input  logic        bit_in,
  output logic        last,
  output logic [BW:0] cnt_sum
);

  logic [BW:0]   cnt_reg;
  logic [BW-1:0] idx_reg;

  assign cnt_sum = cnt_reg + {{BW{1'b0}}, bit_in};
  assign last    = (idx_reg == {BW{1'b1}});

  // Accumulate one stream bit per enabled edge; idx wraps naturally after L-1.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      cnt_reg <= '0;
      idx_reg <= '0;
    end else if (en) begin
      cnt_reg <= cnt_sum;
      idx_reg <= idx_reg + 1'b1;
    end
  end

endmodule

// File: rtl/sn_to_bn.sv
// Stochastic-to-binary converter: counts the ones in a 2**BW-bit window that
// starts after a start pulse and emits one decoded value per window.
// Optional macro S2B_BIPOLAR_EN selects bipolar (offset) decode; the default
// build decodes unipolar. Ports, latency and FSM are the same in both builds.
module sn_to_bn
  import s2b_pkg::*;
#(
  parameter int BW = S2B_BW_DEF
) (
  input  logic          i_clk_s2b,
  input  logic          i_rst_s2b,
  input  logic          i_start_s2b,
  input  logic          i_stop_s2b,
  input  logic          i_sn_bit,
  output logic [BW-1:0] o_bn,
  output logic          o_valid_s2b,
  output logic          o_sat_s2b,
  output logic          o_busy_s2b
);

`ifdef S2B_BIPOLAR_EN
  localparam logic BIPOLAR = 1'b1;
`else
  localparam logic BIPOLAR = 1'b0;
`endif

  localparam logic [BW:0] L_FULL = {1'b1, {BW{1'b0}}};

  s2b_state_t    state_reg, state_next;
  logic [BW-1:0] bn_reg;
  logic          sat_reg;

  logic          cnt_clear;
  logic          cnt_en;
  logic          load;
  logic          last;
  logic [BW:0]   cnt_sum;
  logic [BW-1:0] bn_clip;

  s2b_win_cnt #(.BW(BW)) u_win_cnt (
    .clk     (i_clk_s2b),
    .rst_n   (i_rst_s2b),
    .clear   (cnt_clear),
    .en      (cnt_en),
    .bit_in  (i_sn_bit),
    .last    (last),
    .cnt_sum (cnt_sum)
  );

  assign bn_clip = BW'(s2b_clip(int'(cnt_sum), BIPOLAR, BW));

  // Next-state and counter control; stop outranks start, start outranks counting.
  always_comb begin
    state_next = state_reg;
    cnt_clear  = 1'b0;
    cnt_en     = 1'b0;
    load       = 1'b0;
    if (i_stop_s2b) begin
      state_next = S2B_IDLE;
      cnt_clear  = 1'b1;
    end else begin
      case (state_reg)
        S2B_IDLE: begin
          if (i_start_s2b) begin
            state_next = S2B_ACC;
            cnt_clear  = 1'b1;
          end
        end
        S2B_ACC: begin
          if (i_start_s2b) begin
            cnt_clear = 1'b1;
          end else begin
            cnt_en = 1'b1;
            if (last) begin
              load       = 1'b1;
              state_next = S2B_DONE;
            end
          end
        end
        S2B_DONE: begin
          if (i_start_s2b) begin
            state_next = S2B_ACC;
            cnt_clear  = 1'b1;
          end else begin
            state_next = S2B_IDLE;
          end
        end
        default: state_next = S2B_IDLE;
      endcase
    end
  end

  // State and result registers; the result only changes on a completed window.
  always_ff @(posedge i_clk_s2b) begin
    if (!i_rst_s2b) begin
      state_reg <= S2B_IDLE;
      bn_reg    <= '0;
      sat_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (load) begin
        bn_reg  <= bn_clip;
        sat_reg <= (cnt_sum == L_FULL);
      end
    end
  end

  assign o_bn        = bn_reg;
  assign o_sat_s2b   = sat_reg;
  assign o_valid_s2b = (state_reg == S2B_DONE);
  assign o_busy_s2b  = (state_reg == S2B_ACC);

endmodule

// File: tb/tb_sn_to_bn.sv
// Bench for sn_to_bn (BW=4). A queue-based window model predicts every output
// each cycle; directed scenarios add hand-computed literal expectations.
// Honours S2B_BIPOLAR_EN the same way as the design.
module tb_sn_to_bn;
  import s2b_pkg::*;

  localparam int BW = 4;
  localparam int L  = 16;
`ifdef S2B_BIPOLAR_EN
  localparam logic BIP = 1'b1;
`else
  localparam logic BIP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n, start, stop, sn;
  logic [BW-1:0] bn;
  logic          valid, sat, busy;

  always #5 clk = ~clk;

  sn_to_bn #(.BW(BW)) dut (
    .i_clk_s2b   (clk),
    .i_rst_s2b   (rst_n),
    .i_start_s2b (start),
    .i_stop_s2b  (stop),
    .i_sn_bit    (sn),
    .o_bn        (bn),
    .o_valid_s2b (valid),
    .o_sat_s2b   (sat),
    .o_busy_s2b  (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int valid_cnt = 0;
  int vcyc_q[$];
  bit chk_en = 1'b0;

  // Model state: whether a window is open, the bits collected so far, and the
  // last published result.
  bit            m_open  = 1'b0;
  bit            m_q[$];
  logic [BW-1:0] m_bn    = '0;
  bit            m_sat   = 1'b0;
  bit            m_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Window model driven by the inputs seen on each rising edge.
  always @(posedge clk) begin
    int ones;
    logic [S2B_CLIP_W-1:0] c;
    if (valid === 1'b1) begin
      valid_cnt++;
      vcyc_q.push_back(cyc);
    end
    cyc++;
    m_valid = 1'b0;
    if (!rst_n) begin
      m_open = 1'b0;
      m_q.delete();
      m_bn  = '0;
      m_sat = 1'b0;
    end else if (stop) begin
      m_open = 1'b0;
      m_q.delete();
    end else if (start) begin
      m_open = 1'b1;
      m_q.delete();
    end else if (m_open) begin
      m_q.push_back(sn);
      if (m_q.size() == L) begin
        ones = 0;
        foreach (m_q[k]) ones += int'(m_q[k]);
        c       = s2b_clip(ones, BIP, BW);
        m_bn    = c[BW-1:0];
        m_sat   = (ones == L);
        m_valid = 1'b1;
        m_open  = 1'b0;
        m_q.delete();
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_bn",    bn,    m_bn);
      check("model_valid", valid, m_valid);
      check("model_sat",   sat,   m_sat);
      check("model_busy",  busy,  m_open);
    end
  end

  task automatic open_window();
    @(negedge clk);
    start = 1'b1;
    sn    = 1'b0;
  endtask

  task automatic feed(input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = 1'b0;
      sn    = bits[i];
    end
  endtask

  // Full window; ends on the DONE-cycle negedge with the valid pulse checked.
  task automatic full_window(input logic [15:0] bits);
    open_window();
    feed(bits, L);
    @(negedge clk);
    sn = 1'b0;
    check("valid_latency", valid, 1'b1);
    $display("window bits=%h -> bn=%0d sat=%0d", bits, bn, sat);
  endtask

  function automatic logic [15:0] pattern(input int x);
    logic [31:0] t;
    logic [15:0] v;
    int r;
    t = (x == 0) ? 32'd0 : ((32'd1 << x) - 32'd1);
    v = t[15:0];
    r = (x * 3) % 16;
    if (r != 0) v = (v << r) | (v >> (16 - r));
    return v;
  endfunction

  initial begin
    int v0;
    logic [3:0] prev_exp, exp_v;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; sn = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_bn", bn, 0);
    check("reset_valid", valid, 0);
    check("reset_sat", sat, 0);
    check("reset_busy", busy, 0);
    chk_en = 1'b1;
    rst_n  = 1'b1;

    // Sweep 0..16 ones (16 is the all-ones saturating case).
    for (int x = 0; x <= L; x++) begin
      full_window(pattern(x));
`ifdef S2B_BIPOLAR_EN
      case (x)
        0:  begin check("bip_0",  bn, 4'd8); check("bip_0_sat",  sat, 0); end
        8:  begin check("bip_8",  bn, 4'd0); check("bip_8_sat",  sat, 0); end
        12: begin check("bip_12", bn, 4'd4); check("bip_12_sat", sat, 0); end
        16: begin check("bip_16", bn, 4'd7); check("bip_16_sat", sat, 1); end
        default: ;
      endcase
`else
      check("sweep_bn", bn, (x == L) ? 15 : x);
      check("sweep_sat", sat, (x == L) ? 1 : 0);
`endif
    end

    // Known previous result, then abort at bit 7.
    full_window(16'h001F);
`ifdef S2B_BIPOLAR_EN
    prev_exp = 4'd13;
`else
    prev_exp = 4'd5;
`endif
    check("pre_abort_bn", bn, prev_exp);
    v0 = valid_cnt + 1;
    open_window();
    feed(16'hFFFF, 7);
    @(negedge clk);
    stop = 1'b1;
    sn   = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("abort_busy", busy, 0);
    repeat (20) @(negedge clk);
    check("abort_no_valid", valid_cnt, v0);
    check("abort_bn_held", bn, prev_exp);
    $display("abort at bit 7 -> bn=%0d busy=%0d", bn, busy);

    // Restart at bit 9; only the 16 new bits (8 ones) count.
    open_window();
    feed(16'hFFFF, 9);
    @(negedge clk);
    start = 1'b1;
    sn    = 1'b1;
    feed(16'h00FF, L);
    @(negedge clk);
    sn = 1'b0;
    check("restart_valid", valid, 1);
`ifdef S2B_BIPOLAR_EN
    exp_v = 4'd0;
`else
    exp_v = 4'd8;
`endif
    check("restart_bn", bn, exp_v);
    repeat (3) @(negedge clk);
    check("restart_single", valid_cnt, v0 + 1);
    $display("restart at bit 9 -> bn=%0d", bn);

    // Back-to-back: start in the DONE cycle.
    full_window(16'h0007);
`ifdef S2B_BIPOLAR_EN
    exp_v = 4'd11;
`else
    exp_v = 4'd3;
`endif
    check("b2b_first_bn", bn, exp_v);
    start = 1'b1;
    feed(16'h1F1F, L);
    @(negedge clk);
    sn = 1'b0;
    check("b2b_second_valid", valid, 1);
`ifdef S2B_BIPOLAR_EN
    exp_v = 4'd2;
`else
    exp_v = 4'd10;
`endif
    check("b2b_second_bn", bn, exp_v);
    repeat (2) @(negedge clk);
    if (vcyc_q.size() >= 2)
      check("b2b_spacing", vcyc_q[vcyc_q.size()-1] - vcyc_q[vcyc_q.size()-2], 17);
    else
      check("b2b_pulses", vcyc_q.size(), 2);
    $display("back-to-back -> bn=%0d", bn);

    // Reset mid-window at bit 5.
    v0 = valid_cnt;
    open_window();
    feed(16'hFFFF, 5);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_bn", bn, 0);
    check("rst_mid_valid", valid, 0);
    check("rst_mid_sat", sat, 0);
    check("rst_mid_busy", busy, 0);
    rst_n = 1'b1;
    $display("reset mid-window -> bn=%0d busy=%0d", bn, busy);

    // start and stop together: stays idle.
    @(negedge clk);
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    check("start_stop_busy", busy, 0);
    repeat (20) @(negedge clk);
    check("start_stop_no_valid", valid_cnt, v0);
    $display("start+stop -> busy=%0d", busy);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
